// File: rtl/cc_alu_arbiter_if.sv
// rtl/cc_alu_arbiter_if.sv - requester, ALU and response bundle for the CC_ALU arbiter
interface cc_alu_arbiter_if #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4
);
    logic                               CC_ALUARB_req0Valid_In;
    logic                               CC_ALUARB_req0Ready_Out;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req0DataA_InBus;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req0DataB_InBus;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_req0Sel_InBus;

    logic                               CC_ALUARB_req1Valid_In;
    logic                               CC_ALUARB_req1Ready_Out;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req1DataA_InBus;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_req1DataB_InBus;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_req1Sel_InBus;

    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluDataA_OutBus;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluDataB_OutBus;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_aluSel_OutBus;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluData_InBus;
    logic                               CC_ALUARB_aluOverflow_InLow;
    logic                               CC_ALUARB_aluCarry_InLow;
    logic                               CC_ALUARB_aluNegative_InLow;
    logic                               CC_ALUARB_aluZero_InLow;

    logic                               CC_ALUARB_rspValid_Out;
    logic                               CC_ALUARB_rspReady_In;
    logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_rspData_OutBus;
    logic                               CC_ALUARB_rspOwner_Out;
    logic [3:0]                         CC_ALUARB_psr_OutBus;
    logic                               CC_ALUARB_busy_Out;

    // Arbiter side
    modport slave (
        input  CC_ALUARB_req0Valid_In, CC_ALUARB_req0DataA_InBus, CC_ALUARB_req0DataB_InBus, CC_ALUARB_req0Sel_InBus,
        output CC_ALUARB_req0Ready_Out,
        input  CC_ALUARB_req1Valid_In, CC_ALUARB_req1DataA_InBus, CC_ALUARB_req1DataB_InBus, CC_ALUARB_req1Sel_InBus,
        output CC_ALUARB_req1Ready_Out,
        output CC_ALUARB_aluDataA_OutBus, CC_ALUARB_aluDataB_OutBus, CC_ALUARB_aluSel_OutBus,
        input  CC_ALUARB_aluData_InBus, CC_ALUARB_aluOverflow_InLow, CC_ALUARB_aluCarry_InLow,
        input  CC_ALUARB_aluNegative_InLow, CC_ALUARB_aluZero_InLow,
        output CC_ALUARB_rspValid_Out, CC_ALUARB_rspData_OutBus, CC_ALUARB_rspOwner_Out,
        input  CC_ALUARB_rspReady_In,
        output CC_ALUARB_psr_OutBus, CC_ALUARB_busy_Out
    );

    // Requesters, ALU and response consumer side
    modport master (
        output CC_ALUARB_req0Valid_In, CC_ALUARB_req0DataA_InBus, CC_ALUARB_req0DataB_InBus, CC_ALUARB_req0Sel_InBus,
        input  CC_ALUARB_req0Ready_Out,
        output CC_ALUARB_req1Valid_In, CC_ALUARB_req1DataA_InBus, CC_ALUARB_req1DataB_InBus, CC_ALUARB_req1Sel_InBus,
        input  CC_ALUARB_req1Ready_Out,
        input  CC_ALUARB_aluDataA_OutBus, CC_ALUARB_aluDataB_OutBus, CC_ALUARB_aluSel_OutBus,
        output CC_ALUARB_aluData_InBus, CC_ALUARB_aluOverflow_InLow, CC_ALUARB_aluCarry_InLow,
        output CC_ALUARB_aluNegative_InLow, CC_ALUARB_aluZero_InLow,
        input  CC_ALUARB_rspValid_Out, CC_ALUARB_rspData_OutBus, CC_ALUARB_rspOwner_Out,
        output CC_ALUARB_rspReady_In,
        input  CC_ALUARB_psr_OutBus, CC_ALUARB_busy_Out
    );
endinterface

// File: rtl/cc_alu_arbiter.sv
// rtl/cc_alu_arbiter.sv - round-robin sequencer of the shared CC_ALU with PSR tracking
module cc_alu_arbiter #(
    parameter int                                 DATAWIDTH_BUS           = 32,
    parameter int                                 DATAWIDTH_ALU_SELECTION = 4,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADDCC               = 4'b0011
) (
    input  logic               CC_ALUARB_CLOCK_50,
    input  logic               CC_ALUARB_RESET_InHigh,
    cc_alu_arbiter_if.slave    bus_if
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]                         state_q, state_d;
    logic                               rr_q, rr_d;
    logic [DATAWIDTH_BUS-1:0]           a_q, a_d;
    logic [DATAWIDTH_BUS-1:0]           b_q, b_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0] sel_q, sel_d;
    logic                               owner_q, owner_d;
    logic [DATAWIDTH_BUS-1:0]           rsp_data_q, rsp_data_d;
    logic                               rsp_owner_q, rsp_owner_d;
    logic [3:0]                         psr_q, psr_d;

    logic grant0, grant1;

    // Winner selection: a lone valid wins, a tie goes to the round-robin pointer
    always_comb begin
        grant0 = bus_if.CC_ALUARB_req0Valid_In & (~bus_if.CC_ALUARB_req1Valid_In | ~rr_q);
        grant1 = bus_if.CC_ALUARB_req1Valid_In & (~bus_if.CC_ALUARB_req0Valid_In |  rr_q);
    end

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        owner_d     = owner_q;
        rsp_data_d  = rsp_data_q;
        rsp_owner_d = rsp_owner_q;
        psr_d       = psr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    a_d     = grant1 ? bus_if.CC_ALUARB_req1DataA_InBus : bus_if.CC_ALUARB_req0DataA_InBus;
                    b_d     = grant1 ? bus_if.CC_ALUARB_req1DataB_InBus : bus_if.CC_ALUARB_req0DataB_InBus;
                    sel_d   = grant1 ? bus_if.CC_ALUARB_req1Sel_InBus   : bus_if.CC_ALUARB_req0Sel_InBus;
                    owner_d = grant1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = bus_if.CC_ALUARB_aluData_InBus;
                rsp_owner_d = owner_q;
                if (sel_q == SEL_ADDCC) begin
                    psr_d = {~bus_if.CC_ALUARB_aluNegative_InLow, ~bus_if.CC_ALUARB_aluZero_InLow,
                             ~bus_if.CC_ALUARB_aluOverflow_InLow, ~bus_if.CC_ALUARB_aluCarry_InLow};
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus_if.CC_ALUARB_rspReady_In) begin
                    rr_d    = ~rsp_owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge CC_ALUARB_CLOCK_50) begin
        if (CC_ALUARB_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            owner_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_owner_q <= 1'b0;
            psr_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            owner_q     <= owner_d;
            rsp_data_q  <= rsp_data_d;
            rsp_owner_q <= rsp_owner_d;
            psr_q       <= psr_d;
        end
    end

    // Outputs: ALU ports come only from operand registers so they move only at accept
    always_comb begin
        bus_if.CC_ALUARB_req0Ready_Out   = (state_q == ST_IDLE) & grant0;
        bus_if.CC_ALUARB_req1Ready_Out   = (state_q == ST_IDLE) & grant1;
        bus_if.CC_ALUARB_aluDataA_OutBus = a_q;
        bus_if.CC_ALUARB_aluDataB_OutBus = b_q;
        bus_if.CC_ALUARB_aluSel_OutBus   = sel_q;
        bus_if.CC_ALUARB_rspValid_Out    = (state_q == ST_RESP);
        bus_if.CC_ALUARB_rspData_OutBus  = rsp_data_q;
        bus_if.CC_ALUARB_rspOwner_Out    = rsp_owner_q;
        bus_if.CC_ALUARB_psr_OutBus      = psr_q;
        bus_if.CC_ALUARB_busy_Out        = (state_q != ST_IDLE);
    end
endmodule
